mem_req_arbiter: RTL and testbench

- Shares one memory request/response port between two requesters: port 0 is fetch (instruction), port 1 is the data side.
- Round-robin arbitration with grant locking on stalled requests.
- Memory responses are assumed in order. They are routed back using an internal FIFO of grant IDs, so requester opaque fields pass through unmodified.
- Sits between the Fetch unit / data memory stage and the single memory interface.

---
 rtl/mem_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-port round-robin memory request arbiter with grant locking on stalls.
// Responses return in order and are steered back through a FIFO of grant IDs.
module mem_req_arbiter #(
  parameter int p_addr_bits    = 32,
  parameter int p_data_bits    = 32,
  parameter int p_opaq_bits    = 8,
  parameter int p_max_inflight = 4
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         req0_val,
  output logic                         req0_rdy,
  input  logic                         req0_op,
  input  logic [p_addr_bits-1:0]       req0_addr,
  input  logic [p_data_bits-1:0]       req0_data,
  input  logic [p_opaq_bits-1:0]       req0_opaq,

  input  logic                         req1_val,
  output logic                         req1_rdy,
  input  logic                         req1_op,
  input  logic [p_addr_bits-1:0]       req1_addr,
  input  logic [p_data_bits-1:0]       req1_data,
  input  logic [p_opaq_bits-1:0]       req1_opaq,

  output logic                         resp0_val,
  input  logic                         resp0_rdy,
  output logic                         resp0_op,
  output logic [p_data_bits-1:0]       resp0_data,
  output logic [p_opaq_bits-1:0]       resp0_opaq,

  output logic                         resp1_val,
  input  logic                         resp1_rdy,
  output logic                         resp1_op,
  output logic [p_data_bits-1:0]       resp1_data,
  output logic [p_opaq_bits-1:0]       resp1_opaq,

  output logic                         mem_req_val,
  input  logic                         mem_req_rdy,
  output logic                         mem_req_op,
  output logic [p_addr_bits-1:0]       mem_req_addr,
  output logic [p_data_bits-1:0]       mem_req_data,
  output logic [p_opaq_bits-1:0]       mem_req_opaq,

  input  logic                         mem_resp_val,
  output logic                         mem_resp_rdy,
  input  logic                         mem_resp_op,
  input  logic [p_data_bits-1:0]       mem_resp_data,
  input  logic [p_opaq_bits-1:0]       mem_resp_opaq,

  output logic [$clog2(p_max_inflight):0] inflight
);

  localparam int PW = $clog2(p_max_inflight);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(p_max_inflight);

  logic                      last_grant_q, last_grant_d;
  logic                      lock_valid_q, lock_valid_d;
  logic                      lock_id_q, lock_id_d;
  logic [p_max_inflight-1:0] ids_q, ids_d;
  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;

  logic sel, sel_val, full, empty, head_id, req_fire, resp_fire;

  // A locked grant wins; otherwise a tie goes to whoever did not win last.
  always_comb begin
    sel = 1'b0;
    if (lock_valid_q)
      sel = lock_id_q;
    else if (req0_val ^ req1_val)
      sel = req1_val;
    else if (req0_val && req1_val)
      sel = ~last_grant_q;
  end

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign sel_val = sel ? req1_val : req0_val;
  assign head_id = ids_q[head_q];

  assign mem_req_val  = !rst && sel_val && !full;
  assign mem_req_op   = sel ? req1_op   : req0_op;
  assign mem_req_addr = sel ? req1_addr : req0_addr;
  assign mem_req_data = sel ? req1_data : req0_data;
  assign mem_req_opaq = sel ? req1_opaq : req0_opaq;
  assign req0_rdy     = !rst && !sel && mem_req_rdy && !full;
  assign req1_rdy     = !rst &&  sel && mem_req_rdy && !full;

  assign resp0_val    = !rst && !empty && mem_resp_val && !head_id;
  assign resp1_val    = !rst && !empty && mem_resp_val &&  head_id;
  assign mem_resp_rdy = !rst && !empty && (head_id ? resp1_rdy : resp0_rdy);
  assign resp0_op     = mem_resp_op;
  assign resp0_data   = mem_resp_data;
  assign resp0_opaq   = mem_resp_opaq;
  assign resp1_op     = mem_resp_op;
  assign resp1_data   = mem_resp_data;
  assign resp1_opaq   = mem_resp_opaq;

  assign req_fire  = mem_req_val && mem_req_rdy;
  assign resp_fire = mem_resp_val && mem_resp_rdy;
  assign inflight  = count_q;

  always_comb begin
    last_grant_d = last_grant_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    ids_d        = ids_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    if (req_fire) begin
      ids_d[tail_q] = sel;
      tail_d        = tail_q + PW'(1);
      last_grant_d  = sel;
      lock_valid_d  = 1'b0;
    end else if (mem_req_val) begin
      // Presented but not accepted: pin the grant until it fires.
      lock_valid_d = 1'b1;
      lock_id_d    = sel;
    end
    if (resp_fire)
      head_d = head_q + PW'(1);
    case ({req_fire, resp_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
      ids_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      ids_q        <= ids_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized scoreboard bench for mem_req_arbiter: requesters and memory are
// modelled in the bench, and every routed response is checked against its issuer.
module tb_mem_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OW = 8;
  localparam int MAXI = 4;
  localparam int NCYC = 2000;

  typedef struct packed {
    logic          op;
    logic [DW-1:0] data;
    logic [OW-1:0] opaq;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic req0_val, req0_rdy, req0_op;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic [OW-1:0] req0_opaq;
  logic req1_val, req1_rdy, req1_op;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic [OW-1:0] req1_opaq;
  logic resp0_val, resp0_rdy, resp0_op;
  logic [DW-1:0] resp0_data;
  logic [OW-1:0] resp0_opaq;
  logic resp1_val, resp1_rdy, resp1_op;
  logic [DW-1:0] resp1_data;
  logic [OW-1:0] resp1_opaq;
  logic mem_req_val, mem_req_rdy, mem_req_op;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [OW-1:0] mem_req_opaq;
  logic mem_resp_val, mem_resp_rdy, mem_resp_op;
  logic [DW-1:0] mem_resp_data;
  logic [OW-1:0] mem_resp_opaq;
  logic [$clog2(MAXI):0] inflight;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model state: routing order, per-requester expected replies,
  // the memory's pending replies and the abstract grant history.
  bit    route_q[$];
  resp_t exp_q0[$];
  resp_t exp_q1[$];
  resp_t mem_pend[$];
  bit    m_last, m_lock, m_lock_id;
  bit    fire0, fire1;

  mem_req_arbiter #(
    .p_addr_bits(AW), .p_data_bits(DW), .p_opaq_bits(OW), .p_max_inflight(MAXI)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_op(req0_op),
    .req0_addr(req0_addr), .req0_data(req0_data), .req0_opaq(req0_opaq),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_op(req1_op),
    .req1_addr(req1_addr), .req1_data(req1_data), .req1_opaq(req1_opaq),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_op(resp0_op),
    .resp0_data(resp0_data), .resp0_opaq(resp0_opaq),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_op(resp1_op),
    .resp1_data(resp1_data), .resp1_opaq(resp1_opaq),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_op(mem_req_op),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_opaq(mem_req_opaq),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_op(mem_resp_op),
    .mem_resp_data(mem_resp_data), .mem_resp_opaq(mem_resp_opaq),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // What an in-order memory answers for a request.
  function automatic resp_t mem_reply(logic op, logic [AW-1:0] addr,
                                      logic [DW-1:0] data, logic [OW-1:0] opaq);
    resp_t r;
    r.op   = op;
    r.data = op ? (data + 32'd1) : (addr ^ 32'hDEAD_BEEF);
    r.opaq = opaq;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input int cyc);
    int p0, p1, prdy, prv, prr;
    case (cyc / 400)
      0:       begin p0 = 60; p1 = 60; prdy = 80; prv = 70; prr = 80; end
      1:       begin p0 = 70; p1 = 0;  prdy = 70; prv = 70; prr = 80; end
      2:       begin p0 = 90; p1 = 90; prdy = 30; prv = 70; prr = 80; end
      3:       begin p0 = 30; p1 = 90; prdy = 90; prv = 8;  prr = 90; end
      default: begin p0 = 60; p1 = 60; prdy = 80; prv = 80; prr = 25; end
    endcase
    rst = (cyc == 1000 || cyc == 1801);
    if (!(req0_val && !fire0)) begin
      req0_val  = ($urandom_range(0, 99) < p0);
      req0_op   = 1'($urandom);
      req0_addr = $urandom;
      req0_data = $urandom;
      req0_opaq = OW'($urandom);
    end
    if (!(req1_val && !fire1)) begin
      req1_val  = ($urandom_range(0, 99) < p1);
      req1_op   = 1'($urandom);
      req1_addr = $urandom;
      req1_data = $urandom;
      req1_opaq = OW'($urandom);
    end
    mem_req_rdy = ($urandom_range(0, 99) < prdy);
    if (mem_pend.size() > 0) begin
      mem_resp_val  = ($urandom_range(0, 99) < prv);
      mem_resp_op   = mem_pend[0].op;
      mem_resp_data = mem_pend[0].data;
      mem_resp_opaq = mem_pend[0].opaq;
    end else begin
      mem_resp_val  = ($urandom_range(0, 99) < 10);
      mem_resp_op   = 1'($urandom);
      mem_resp_data = $urandom;
      mem_resp_opaq = OW'($urandom);
    end
    resp0_rdy = ($urandom_range(0, 99) < prr);
    resp1_rdy = ($urandom_range(0, 99) < prr);
  endtask

  // Monitor: evaluates the model mid-cycle and pops the scoreboard on fires.
  always @(negedge clk) begin
    bit exp_full, exp_sel, exp_mval, nonempty, h;
    resp_t got, want;
    fire0 = 1'b0;
    fire1 = 1'b0;
    if (rst) begin
      check_output("reset_handshakes",
                   {req0_rdy, req1_rdy, mem_req_val, resp0_val, resp1_val, mem_resp_rdy}, 0);
      route_q.delete();
      exp_q0.delete();
      exp_q1.delete();
      mem_pend.delete();
      m_last = 1'b1;
      m_lock = 1'b0;
      m_lock_id = 1'b0;
    end else begin
      check_output("inflight", inflight, route_q.size());
      exp_full = (route_q.size() == MAXI);
      if (m_lock)                     exp_sel = m_lock_id;
      else if (req0_val && !req1_val) exp_sel = 1'b0;
      else if (req1_val && !req0_val) exp_sel = 1'b1;
      else if (req0_val && req1_val)  exp_sel = !m_last;
      else                            exp_sel = 1'b0;
      exp_mval = (exp_sel ? req1_val : req0_val) && !exp_full;
      check_output("req_handshake", {mem_req_val, req0_rdy, req1_rdy},
                   {exp_mval, !exp_sel && mem_req_rdy && !exp_full,
                    exp_sel && mem_req_rdy && !exp_full});
      if (exp_mval)
        check_output("mem_req_fields", {mem_req_op, mem_req_addr, mem_req_data, mem_req_opaq},
                     exp_sel ? {req1_op, req1_addr, req1_data, req1_opaq}
                             : {req0_op, req0_addr, req0_data, req0_opaq});

      nonempty = (route_q.size() > 0);
      h = nonempty ? route_q[0] : 1'b0;
      check_output("resp_handshake", {resp0_val, resp1_val, mem_resp_rdy},
                   {mem_resp_val && nonempty && !h, mem_resp_val && nonempty && h,
                    nonempty && (h ? resp1_rdy : resp0_rdy)});
      if (resp0_val && resp0_rdy) begin
        got = {resp0_op, resp0_data, resp0_opaq};
        if (exp_q0.size() == 0) begin
          n_vectors++; n_miscompares++;
          $display("[TB] FAIL resp0_unexpected: got %0h expected no response", got);
        end else begin
          want = exp_q0.pop_front();
          check_output("resp0_payload", got, want);
        end
      end
      if (resp1_val && resp1_rdy) begin
        got = {resp1_op, resp1_data, resp1_opaq};
        if (exp_q1.size() == 0) begin
          n_vectors++; n_miscompares++;
          $display("[TB] FAIL resp1_unexpected: got %0h expected no response", got);
        end else begin
          want = exp_q1.pop_front();
          check_output("resp1_payload", got, want);
        end
      end
      if (mem_resp_val && mem_resp_rdy) begin
        if (route_q.size() > 0) void'(route_q.pop_front());
        if (mem_pend.size() > 0) void'(mem_pend.pop_front());
      end

      fire0 = req0_val && req0_rdy;
      fire1 = req1_val && req1_rdy;
      if (fire0) exp_q0.push_back(mem_reply(req0_op, req0_addr, req0_data, req0_opaq));
      if (fire1) exp_q1.push_back(mem_reply(req1_op, req1_addr, req1_data, req1_opaq));
      if (mem_req_val && mem_req_rdy) begin
        mem_pend.push_back(mem_reply(mem_req_op, mem_req_addr, mem_req_data, mem_req_opaq));
        route_q.push_back(exp_sel);
        m_last = exp_sel;
        m_lock = 1'b0;
      end else if (exp_mval && !mem_req_rdy) begin
        m_lock = 1'b1;
        m_lock_id = exp_sel;
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_val = 0; req0_op = 0; req0_addr = 0; req0_data = 0; req0_opaq = 0;
    req1_val = 0; req1_op = 0; req1_addr = 0; req1_data = 0; req1_opaq = 0;
    resp0_rdy = 0; resp1_rdy = 0; mem_req_rdy = 0;
    mem_resp_val = 0; mem_resp_op = 0; mem_resp_data = 0; mem_resp_opaq = 0;
    repeat (3) @(posedge clk);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      apply_stimulus(cyc);
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
